// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters; latches operands,
// sequences the ALU and returns a registered result. Optional opcode check: ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int DATA_W      = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [2:0]        ctrl0,
  input  logic [2:0]        ctrl1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
`ifdef ALU_ARB_OPCHECK_EN
  ,
  output logic              err
`endif
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state, next_state;
  logic [CW-1:0]     cnt;
  logic              win;
  logic              last_served;
  logic              any_req;
  logic              pick1;
  logic              bad_op;
  logic [2:0]        sel_ctrl;
  logic [DATA_W-1:0] sel_a, sel_b;

  // On a tie the port that was not served last wins; a lone request always wins.
  always_comb begin
    any_req  = req0 | req1;
    pick1    = req1 & (~req0 | ~last_served);
    sel_ctrl = pick1 ? ctrl1 : ctrl0;
    sel_a    = pick1 ? a1 : a0;
    sel_b    = pick1 ? b1 : b0;
`ifdef ALU_ARB_OPCHECK_EN
    bad_op   = (sel_ctrl == 3'd4) || (sel_ctrl == 3'd7);
`else
    bad_op   = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = bad_op ? DONE : EXEC;
      EXEC:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Grant/done are single-cycle pulses; the ALU inputs hold their latched values
  // from grant until the next grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      alu_control <= 3'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      cnt         <= '0;
      win         <= 1'b0;
      last_served <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
      err         <= 1'b0;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            win         <= pick1;
            last_served <= pick1;
            gnt0        <= ~pick1;
            gnt1        <= pick1;
            alu_control <= sel_ctrl;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            cnt         <= CW'(EXEC_CYCLES - 1);
`ifdef ALU_ARB_OPCHECK_EN
            if (bad_op) begin
              done0 <= ~pick1;
              done1 <= pick1;
              err   <= 1'b1;
            end
`endif
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result <= alu_out;
            zero   <= alu_zero;
            done0  <= ~win;
            done1  <= win;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
